bp_fe_pc_pipe_ras: RTL

Parametrised front-end fetch-PC pipeline with a configurable number of in-flight fetch stages and an integrated return-address stack (RAS). It produces the next fetch PC for the I-cache/ITLB and tracks outstanding fetches through `stages_p` pipeline slots. It applies branch-target-buffer (BTB) predictions and predecode overrides for jal, call and ret, replays on miss or queue backpressure, and emits retired fetch PCs to the FE queue. It sits between the backend command decoder and the I-cache, in place of the fixed two-stage PC generator.

---
 rtl/bp_fe_pc_pipe_ras.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bp_fe_pc_pipe_ras.sv
// Fetch-PC pipeline with a configurable number of in-flight stages and an
// integrated return-address stack. Produces the next fetch PC (npc), tracks
// outstanding fetches, applies BTB/predecode overrides and replays on miss.
module bp_fe_pc_pipe_ras #(
  parameter int unsigned vaddr_width_p = 39,
  parameter int unsigned stages_p      = 2,
  parameter int unsigned ras_depth_p   = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               redirect_v_i,
  input  logic [vaddr_width_p-1:0]           redirect_pc_i,
  output logic [vaddr_width_p-1:0]           fetch_pc_o,
  output logic                               fetch_v_o,
  input  logic                               fetch_yumi_i,
  input  logic                               btb_tgt_v_i,
  input  logic [vaddr_width_p-1:0]           btb_tgt_i,
  input  logic                               resp_v_i,
  input  logic                               resp_is_jal_i,
  input  logic                               resp_is_call_i,
  input  logic                               resp_is_ret_i,
  input  logic [vaddr_width_p-1:0]           resp_tgt_i,
  input  logic                               queue_ready_i,
  output logic                               out_v_o,
  output logic [vaddr_width_p-1:0]           out_pc_o,
  output logic                               out_pred_taken_o,
  output logic [stages_p-1:0]                poison_o,
  output logic [$clog2(ras_depth_p+1)-1:0]   ras_count_o
);

  localparam int unsigned last_lp  = stages_p - 1;
  localparam int unsigned ptr_w_lp = $clog2(ras_depth_p);
  localparam int unsigned cnt_w_lp = $clog2(ras_depth_p + 1);

  typedef enum logic {e_wait, e_run} state_e;

  state_e state_q, state_d;

  logic [stages_p-1:0]      v_q, v_d;
  logic [stages_p-1:0]      pt_q, pt_d;
  logic [vaddr_width_p-1:0] pc_q [stages_p];
  logic [vaddr_width_p-1:0] pc_d [stages_p];
  logic [vaddr_width_p-1:0] resume_q;

  logic [vaddr_width_p-1:0] ras_q [ras_depth_p];
  logic [ptr_w_lp-1:0]      tp_q, tp_d;
  logic [cnt_w_lp-1:0]      cnt_q, cnt_d;
  logic                     ras_we;
  logic [ptr_w_lp-1:0]      ras_waddr;
  logic [vaddr_width_p-1:0] ras_wdata;

  logic                     accept, replay, retire, ras_hit, ovr, kill_all;
  logic [vaddr_width_p-1:0] ovr_tgt, npc;
  logic [stages_p-1:0]      kill;

  // Control decode for the oldest stage and the fetch handshake.
  always_comb begin
    fetch_v_o = (state_q == e_run) | redirect_v_i;
    accept    = fetch_v_o & fetch_yumi_i;
    replay    = v_q[last_lp] & ~(resp_v_i & queue_ready_i) & ~redirect_v_i;
    retire    = v_q[last_lp] & resp_v_i & queue_ready_i & ~redirect_v_i;
    ras_hit   = (cnt_q != '0);
    ovr       = retire & ~pt_q[last_lp] & (resp_is_jal_i | (resp_is_ret_i & ras_hit));
    ovr_tgt   = resp_is_ret_i ? ras_q[tp_q] : resp_tgt_i;
    kill_all  = redirect_v_i | replay;
  end

  // Next fetch PC, first match wins.
  always_comb begin
    npc = resume_q;
    if (redirect_v_i)                npc = redirect_pc_i;
    else if (replay)                 npc = pc_q[last_lp];
    else if (ovr)                    npc = ovr_tgt;
    else if (v_q[0] && btb_tgt_v_i)  npc = btb_tgt_i;
    else if (v_q[0])                 npc = pc_q[0] + vaddr_width_p'(4);
  end

  // Kill vector and stage shift; the newly accepted stage-0 entry is never killed.
  always_comb begin
    kill = '0;
    v_d  = '0;
    pt_d = '0;
    for (int unsigned i = 0; i < stages_p; i++) begin
      kill[i] = kill_all | (ovr & (i != last_lp));
      pc_d[i] = pc_q[i];
    end
    v_d[0]  = accept;
    pc_d[0] = npc;
    pt_d[0] = 1'b0;
    for (int unsigned i = 1; i < stages_p; i++) begin
      v_d[i]  = v_q[i-1] & ~kill[i-1];
      pc_d[i] = pc_q[i-1];
      pt_d[i] = (i == 1) ? (v_q[0] & btb_tgt_v_i) : pt_q[i-1];
    end
  end

  // FSM next state: leaves e_wait on the first redirect and stays in e_run.
  always_comb begin
    state_d = state_q;
    if ((state_q == e_wait) && redirect_v_i) state_d = e_run;
  end

  // RAS update on retire; call+ret overwrites the top in place.
  always_comb begin
    tp_d      = tp_q;
    cnt_d     = cnt_q;
    ras_we    = 1'b0;
    ras_waddr = tp_q;
    ras_wdata = pc_q[last_lp] + vaddr_width_p'(4);
    if (retire) begin
      if (resp_is_call_i && resp_is_ret_i) begin
        ras_we = 1'b1;
        if (cnt_q == '0) cnt_d = cnt_w_lp'(1);
      end else if (resp_is_call_i) begin
        tp_d      = tp_q + ptr_w_lp'(1);
        ras_waddr = tp_q + ptr_w_lp'(1);
        ras_we    = 1'b1;
        if (cnt_q != cnt_w_lp'(ras_depth_p)) cnt_d = cnt_q + cnt_w_lp'(1);
      end else if (resp_is_ret_i && ras_hit) begin
        tp_d  = tp_q - ptr_w_lp'(1);
        cnt_d = cnt_q - cnt_w_lp'(1);
      end
    end
  end

  // State, stage, resume and RAS pointer registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_wait;
      v_q      <= '0;
      pt_q     <= '0;
      resume_q <= '0;
      tp_q     <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < stages_p; i++) pc_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      pt_q     <= pt_d;
      resume_q <= npc;
      tp_q     <= tp_d;
      cnt_q    <= cnt_d;
      for (int unsigned i = 0; i < stages_p; i++) pc_q[i] <= pc_d[i];
    end
  end

  // RAS storage; contents are meaningless while count is zero.
  always_ff @(posedge clk_i) begin
    if (ras_we && !reset_i) ras_q[ras_waddr] <= ras_wdata;
  end

  // Output drive.
  always_comb begin
    fetch_pc_o       = npc;
    out_v_o          = retire;
    out_pc_o         = pc_q[last_lp];
    out_pred_taken_o = pt_q[last_lp] | ovr;
    poison_o         = v_q & kill;
    ras_count_o      = cnt_q;
  end

endmodule
